// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue -- instruction-fetch stage sitting right after the PC register.
//
// Issues one fetch per cycle to instruction memory (valid/ready), tags every
// accepted request with its PC, and buffers {pc, instruction} pairs in a
// DEPTH-entry FIFO that feeds IF/ID. hold_pc_o goes to the PC's active-low
// enable, so the PC only advances when a request is accepted or when it must
// load a redirect target on flush.
//
// Credit rule: count + outstanding + discard < DEPTH gates new requests, so
// every response that is not discarded is guaranteed a FIFO slot.
//
// Optional build macro: FETCH_QUEUE_BYPASS_EN
//   When defined, a response arriving while the FIFO is empty (and nothing is
//   pending discard) is presented on the decode outputs in the same cycle.
//   When undefined, decode outputs always come from FIFO storage.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-low reset
//   start_i                      run enable; 0 blocks new requests
//   flush_i                      redirect; kills queued and in-flight fetches
//   pc_i                         current PC
//   hold_pc_o                    1 = PC must hold
//   imem_req_valid_o/ready_i     fetch request handshake
//   imem_addr_o                  fetch address (= pc_i)
//   imem_rsp_valid_i/data_i      in-order response, never back-pressured
//   inst_valid_o/inst_o/inst_pc_o head of queue to decode
//   inst_ready_i                 decode consumes head
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              hold_pc_o,
    output logic              imem_req_valid_o,
    input  logic              imem_req_ready_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_rsp_valid_i,
    input  logic [DATA_W-1:0] imem_rsp_data_i,
    output logic              inst_valid_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    input  logic              inst_ready_i
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 2;

    typedef logic [SW-1:0] sum_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] inst;
    } entry_t;

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    entry_t            fifo_q [DEPTH];
    logic [ADDR_W-1:0] tag_q  [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr, tag_wr, tag_rd;
    logic [CW-1:0]     count, outstanding, discard;

    sum_t              credits_used;
    logic              accept;
    logic              rsp_live;
    logic              bypass;
    logic              fifo_push;
    logic              fifo_pop;
    logic [ADDR_W-1:0] rsp_tag;

    // ---------------- request side ----------------
    assign credits_used     = sum_t'(count) + sum_t'(outstanding) + sum_t'(discard);
    assign imem_req_valid_o = rst_i & start_i & ~flush_i & (credits_used < sum_t'(DEPTH));
    assign imem_addr_o      = pc_i;
    assign accept           = imem_req_valid_o & imem_req_ready_i;

    // Flush lets the PC load its redirect target; a stopped CPU never moves it.
    assign hold_pc_o = ~(rst_i & (accept | (flush_i & start_i)));

    // ---------------- response side ----------------
    // A response is "live" when it is not one of the post-flush leftovers.
    assign rsp_live = imem_rsp_valid_i & (discard == '0);
    assign rsp_tag  = tag_q[tag_rd];

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = rst_i & rsp_live & (count == '0);
`else
    assign bypass = 1'b0;
`endif

    assign inst_valid_o = rst_i & ((count != '0) | bypass);
    assign inst_o       = bypass ? imem_rsp_data_i : fifo_q[rd_ptr].inst;
    assign inst_pc_o    = bypass ? rsp_tag         : fifo_q[rd_ptr].pc;

    // A bypassed response consumed by decode never touches storage.
    assign fifo_push = rsp_live & ~(bypass & inst_ready_i);
    assign fifo_pop  = (count != '0) & inst_ready_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else if (flush_i) begin
            // Everything in flight becomes discard work; a response landing in
            // this very cycle already retires one of them.
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= discard + outstanding - CW'(imem_rsp_valid_i);
        end else begin
            if (accept) begin
                tag_q[tag_wr] <= pc_i;
                tag_wr        <= tag_wr + PW'(1);
            end
            if (rsp_live)
                tag_rd <= tag_rd + PW'(1);
            if (fifo_push) begin
                fifo_q[wr_ptr] <= '{pc: rsp_tag, inst: imem_rsp_data_i};
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (fifo_pop)
                rd_ptr <= rd_ptr + PW'(1);
            count       <= count + CW'(fifo_push) - CW'(fifo_pop);
            outstanding <= outstanding + CW'(accept) - CW'(rsp_live);
            if (imem_rsp_valid_i && (discard != '0))
                discard <= discard - CW'(1);
        end
    end

`ifndef SYNTHESIS
    // The credit rule makes this unreachable; firing means memory returned
    // more responses than were requested.
    always_ff @(posedge clk_i) begin
        if (rst_i && !flush_i)
            assert (!(rsp_live && (count == FULL)))
                else $error("fetch_queue: response arrived with FIFO full");
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i, flush_i;
    logic [31:0] pc_i;
    logic        hold_pc_o;
    logic        imem_req_valid_o, imem_req_ready_i;
    logic [31:0] imem_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        inst_valid_o;
    logic [31:0] inst_o, inst_pc_o;
    logic        inst_ready_i;

    fetch_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .start_i          (start_i),
        .flush_i          (flush_i),
        .pc_i             (pc_i),
        .hold_pc_o        (hold_pc_o),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_addr_o      (imem_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .inst_valid_o     (inst_valid_o),
        .inst_o           (inst_o),
        .inst_pc_o        (inst_pc_o),
        .inst_ready_i     (inst_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    typedef struct {
        bit ir;
        bit e_req;
        bit e_hold;
        bit e_iv;
    } vec_t;

    exp_t        exp_q[$];
    logic [31:0] mem_q[$];
    logic [31:0] acc_log[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          auto_mem = 1'b0;
    bit          sb_en    = 1'b1;
    logic [31:0] flush_tgt = '0;

    logic        s_req, s_acc, s_hold, s_iv;
    logic [31:0] s_addr, s_ipc, s_inst;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return 32'h00A0_0013 ^ (a << 7);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: sample at negedge, score, then advance PC and memory.
    task automatic cyc();
        exp_t        e;
        logic [31:0] a;
        @(negedge clk_i);
        s_req  = imem_req_valid_o;
        s_acc  = imem_req_valid_o & imem_req_ready_i;
        s_addr = imem_addr_o;
        s_hold = hold_pc_o;
        s_iv   = inst_valid_o;
        s_ipc  = inst_pc_o;
        s_inst = inst_o;
        chk("hold_pc", 32'(s_hold), 32'(!(rst_i && (s_acc || (flush_i && start_i)))));
        if (sb_en && s_iv && inst_ready_i && !flush_i) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_extra: got pc %h, no instruction expected", s_ipc);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", s_ipc, e.pc);
                chk("sb_inst", s_inst, e.inst);
            end
        end
        if (flush_i) exp_q.delete();
        if (s_acc) begin
            acc_log.push_back(s_addr);
            exp_q.push_back('{s_addr, mdata(s_addr)});
            if (auto_mem) mem_q.push_back(s_addr);
        end
        @(posedge clk_i);
        #1;
        if (!s_hold) pc_i = flush_i ? flush_tgt : pc_i + 32'd4;
        flush_i          = 1'b0;
        imem_rsp_valid_i = 1'b0;
        if (auto_mem && mem_q.size() > 0) begin
            a = mem_q.pop_front();
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = mdata(a);
        end
    endtask

    task automatic do_reset();
        rst_i            = 1'b0;
        start_i          = 1'b1;
        flush_i          = 1'b0;
        imem_req_ready_i = 1'b1;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        inst_ready_i     = 1'b0;
        pc_i             = '0;
        auto_mem         = 1'b0;
        mem_q.delete();
        exp_q.delete();
        acc_log.delete();
        @(negedge clk_i);
        chk("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
        chk("rst_hold",      32'(hold_pc_o),        32'd1);
        chk("rst_inst_valid",32'(inst_valid_o),     32'd0);
        chk("rst_inst",      inst_o,                32'd0);
        chk("rst_inst_pc",   inst_pc_o,             32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
    endtask

    task automatic drain();
        start_i          = 1'b0;
        inst_ready_i     = 1'b1;
        imem_req_ready_i = 1'b1;
        auto_mem         = 1'b1;
        for (int i = 0; i < 40 && (exp_q.size() > 0 || mem_q.size() > 0); i++) cyc();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        cyc();
        chk("drain_idle", 32'(s_iv), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[10];
        logic [31:0] inst_c2, inst_c3;

        // credit/back-pressure table: decode stalled, memory ready, 1-cycle response
        vt[0] = '{0, 1, 0, 0};
        vt[1] = '{0, 1, 0, BYP};
        vt[2] = '{0, 1, 0, 1};
        vt[3] = '{0, 1, 0, 1};
        vt[4] = '{0, 0, 1, 1};
        vt[5] = '{0, 0, 1, 1};
        vt[6] = '{1, 0, 1, 1};
        vt[7] = '{0, 1, 0, 1};
        vt[8] = '{0, 0, 1, 1};
        vt[9] = '{0, 0, 1, 1};

        // ---- streaming fetch from 0x0 ----
        do_reset();
        inst_ready_i = 1'b1;
        auto_mem     = 1'b1;
        cyc(); chk("lat_c1_iv", 32'(s_iv), 32'd0);
        cyc(); chk("lat_c2_iv", 32'(s_iv), 32'(BYP));
        cyc(); chk("lat_c3_iv", 32'(s_iv), 32'd1);
        for (int i = 0; i < 10; i++) cyc();
        chk("stream_a0", acc_log[0], 32'h0);
        chk("stream_a1", acc_log[1], 32'h4);
        chk("stream_a2", acc_log[2], 32'h8);
        drain();

        // ---- credit limit with decode stalled ----
        do_reset();
        auto_mem = 1'b1;
        for (int i = 0; i < 10; i++) begin
            inst_ready_i = vt[i].ir;
            cyc();
            chk($sformatf("tbl%0d_req", i),  32'(s_req),  32'(vt[i].e_req));
            chk($sformatf("tbl%0d_hold", i), 32'(s_hold), 32'(vt[i].e_hold));
            chk($sformatf("tbl%0d_iv", i),   32'(s_iv),   32'(vt[i].e_iv));
        end
        chk("credit_n_acc", 32'(acc_log.size()), 32'd5);
        chk("credit_a4", acc_log[4], 32'h10);
        drain();

        // ---- flush with 2 outstanding and 1 queued ----
        do_reset();
        cyc();                                                  // accept 0x0
        imem_rsp_valid_i = 1'b1; imem_rsp_data_i = mdata(32'h0);
        cyc();                                                  // accept 0x4, 0x0 queued
        cyc();                                                  // accept 0x8
        flush_i = 1'b1; flush_tgt = 32'h100;
        cyc();
        chk("fl_req", 32'(s_req), 32'd0);
        imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'hAAAA_0001;
        cyc();                                                  // accept 0x100, drop
        chk("fl_c5_iv", 32'(s_iv), 32'd0);
        chk("fl_c5_addr", s_addr, 32'h100);
        imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'hAAAA_0002; imem_req_ready_i = 1'b0;
        cyc();
        chk("fl_c6_iv", 32'(s_iv), 32'd0);
        imem_rsp_valid_i = 1'b1; imem_rsp_data_i = mdata(32'h100);
        cyc();
        chk("fl_c7_iv", 32'(s_iv), 32'(BYP));
        cyc();
        chk("fl_c8_iv", 32'(s_iv), 32'd1);
        chk("fl_c8_pc", s_ipc, 32'h100);
        chk("fl_c8_inst", s_inst, mdata(32'h100));
        drain();

        // ---- flush coinciding with a response and a pop ----
        do_reset();
        pc_i = 32'h40;
        cyc();                                                  // accept 0x40
        imem_rsp_valid_i = 1'b1; imem_rsp_data_i = mdata(32'h40);
        cyc();                                                  // accept 0x44
        cyc();                                                  // accept 0x48
        flush_i = 1'b1; flush_tgt = 32'h200; inst_ready_i = 1'b1;
        imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'hAAAA_0003;
        cyc();
        chk("fr_req", 32'(s_req), 32'd0);
        inst_ready_i = 1'b0; imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'hAAAA_0004;
        cyc();
        chk("fr_c5_iv", 32'(s_iv), 32'd0);
        imem_req_ready_i = 1'b1;
        cyc();
        chk("fr_c6_iv", 32'(s_iv), 32'd0);
        chk("fr_c6_acc", 32'(s_acc), 32'd1);
        chk("fr_c6_addr", s_addr, 32'h200);
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b1; imem_rsp_data_i = mdata(32'h200);
        cyc();
        chk("fr_c7_iv", 32'(s_iv), 32'(BYP));
        cyc();
        chk("fr_c8_iv", 32'(s_iv), 32'd1);
        chk("fr_c8_pc", s_ipc, 32'h200);
        drain();

        // ---- memory ready toggling, 16 fetches ----
        do_reset();
        inst_ready_i = 1'b1;
        auto_mem     = 1'b1;
        for (int i = 0; i < 200 && acc_log.size() < 16; i++) begin
            imem_req_ready_i = (i % 3) != 1;
            cyc();
        end
        chk("tog_n_acc", 32'(acc_log.size()), 32'd16);
        foreach (acc_log[k]) chk($sformatf("tog_addr%0d", k), acc_log[k], 32'(k * 4));
        drain();

        // ---- empty-queue response with decode ready ----
        do_reset();
        sb_en        = 1'b0;
        pc_i         = 32'h300;
        inst_ready_i = 1'b1;
        cyc();                                                  // accept 0x300
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'h0050_0093;
        cyc();
        chk("byp_c2_iv", 32'(s_iv), 32'(BYP));
        inst_c2 = s_inst;
        cyc();
        chk("byp_c3_iv", 32'(s_iv), 32'(!BYP));
        inst_c3 = s_inst;
        chk("byp_inst", BYP ? inst_c2 : inst_c3, 32'h0050_0093);
        cyc();
        chk("byp_c4_iv", 32'(s_iv), 32'd0);
        exp_q.delete();
        sb_en = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Takes the current PC and issues requests to instruction memory over a valid/ready handshake.
- Buffers returned instructions with their PCs in a DEPTH-entry FIFO and presents them to the IF/ID register/decode.
- Drives `hold_pc_o` back to the PC's active-low enable, so the PC advances only when a fetch request is accepted.

Parameters:
DEPTH, 4, FIFO entries and maximum (queued + outstanding) fetches; power of two, 2..16
ADDR_W, 32, PC/address width
DATA_W, 32, instruction width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-low
start_i  in  1  CPU run enable; 0 = issue no requests
flush_i  in  1  branch/jump redirect; kill queued and in-flight fetches
pc_i  in  ADDR_W  current PC (PC register output)
hold_pc_o  out  1  1 = PC must hold (wired to PC pcEnable_i)
imem_req_valid_o  out  1  fetch request valid
imem_req_ready_i  in  1  memory accepts request
imem_addr_o  out  ADDR_W  fetch address
imem_rsp_valid_i  in  1  response valid; in order, one per accepted request, never back-pressured
imem_rsp_data_i  in  DATA_W  fetched instruction
inst_valid_o  out  1  head entry valid
inst_o  out  DATA_W  head instruction
inst_pc_o  out  ADDR_W  PC of head instruction
inst_ready_i  in  1  decode consumes head (0 = decode stall)

Behaviour:
- Reset (`rst_i` = 0, asynchronous):
  - FIFO pointers, count, outstanding counter, discard counter and address-tracking FIFO all cleared.
  - `inst_valid_o` = 0, `imem_req_valid_o` = 0, `hold_pc_o` = 1.
  - `inst_o` and `inst_pc_o` = 0.
- State:
  - `count` (0..DEPTH): number of valid FIFO entries.
  - `outstanding` (0..DEPTH): requests accepted but not yet answered.
  - `discard` (0..DEPTH): responses still to be dropped after a flush.
  - Internal PC-tag FIFO of DEPTH entries: holds the address of each live request so `inst_pc_o` is paired with its instruction.
- Request issue:
  - `imem_req_valid_o` = `start_i` & ~`flush_i` & (`count` + `outstanding` + `discard` < DEPTH).
  - `imem_addr_o` = `pc_i` (combinational).
  - Accept = `imem_req_valid_o` & `imem_req_ready_i`.
- PC control:
  - `hold_pc_o` = ~(accept | `flush_i`). The PC advances on the accept cycle, and loads the redirect target on the flush cycle.
  - When `start_i` = 0, `hold_pc_o` = 1.
- Response handling:
  - If `discard` > 0: drop the data and decrement `discard`.
  - Otherwise: write {tag, data} at the FIFO tail, increment `count`, decrement `outstanding`.
- Overflow: the credit rule guarantees no overflow. An impossible response at `count` = DEPTH is an assertion failure.
- Decode side:
  - `inst_valid_o` = (`count` > 0); head registered from the FIFO.
  - Pop on `inst_valid_o` & `inst_ready_i`.
  - Push and pop in the same cycle leave `count` unchanged.
  - Latency: response at cycle N is visible at the head at N+1.
- Flush (wins over every other event in that cycle):
  - FIFO cleared and `count` = 0; `inst_valid_o` = 0 next cycle.
  - `discard` = `discard` + `outstanding` − (1 if a response arrives this cycle).
  - `outstanding` = 0; tag FIFO reset.
  - No request issued in the flush cycle.
  - Pop during flush is ignored.
- `start_i` falling: no new requests. Queue and in-flight fetches drain normally. `start_i` is not a flush.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally; `count` disambiguates full from empty.
- Reset mid-operation: all state cleared immediately. Memory is assumed reset together with this block.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined: when the FIFO is empty, `discard` = 0 and `imem_rsp_valid_i` = 1, the response appears the same cycle.
  - `inst_valid_o` = 1, `inst_o` = `imem_rsp_data_i`, `inst_pc_o` = matching tag.
  - If `inst_ready_i` = 1 it is consumed without being written; otherwise it is written normally.
  - Latency becomes 0 cycles.
- Undefined: all outputs are registered from the FIFO; latency 1 cycle.

Test Plan:
- Reset release, `start_i` = 1, `pc_i` = 0x0, memory always ready with 1-cycle response -> requests at 0x0, 0x4, 0x8; `inst_pc_o`/`inst_o` pairs emerge in order; `hold_pc_o` = 0 on each accept.
- `inst_ready_i` held 0, DEPTH = 4 -> exactly 4 requests accepted, then `imem_req_valid_o` = 0 and `hold_pc_o` = 1; one pop re-enables one request.
- Flush with 2 outstanding and 1 queued, then responses 0xAAAA0001/0xAAAA0002 arrive -> both dropped; the first valid instruction carries the post-flush `pc_i` (0x100).
- Flush in the same cycle as a response and a pop -> `discard` = `outstanding` − 1, `count` = 0; no request that cycle.
- `imem_req_ready_i` toggling 1-0-1 -> PC advances only on accept cycles; no duplicate or missing addresses over 16 fetches.
- With FETCH_QUEUE_BYPASS_EN, empty queue, response 0x00500093 with `inst_ready_i` = 1 -> `inst_valid_o` = 1 in the response cycle and `count` stays 0.
